control_sequencer: RTL and testbench

Multicycle fetch/decode/execute sequencer for the 8-bit tiny CPU. It owns the program counter and instruction register, runs memory read handshakes, and drives the accumulator-path 2:1 mux select. It also drives the ALU operation and the accumulator load enable. It sits directly upstream of the accumulator mux: `mux_sel` and `imm_ext` feed that mux, and its output feeds the accumulator.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/instr_decode.sv | 33 +++
 rtl/control_sequencer.sv | 116 +++++++++++
 tb/tb_control_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU op and sequencer state definitions for the tiny CPU
package cpu_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  function automatic logic [7:0] zext5(input logic [4:0] v);
    return {3'b000, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction class and ALU op decode
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_mem_op,
  output logic       is_ldi,
  output logic       is_jump,
  output logic       is_jz,
  output logic       is_hlt,
  output logic [1:0] alu_op
);

  logic [2:0] opcode;

  assign opcode    = ir[7:5];
  assign is_mem_op = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
  assign is_ldi    = (opcode == OP_LDI);
  assign is_jump   = (opcode == OP_JMP);
  assign is_jz     = (opcode == OP_JZ);
  assign is_hlt    = (opcode == OP_HLT);

  always_comb begin
    alu_op = ALU_PASS;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_PASS;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multicycle fetch/decode/execute sequencer owning pc, ir and operand
module control_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  input  logic       zero_flag,
  output logic       mux_sel,
  output logic [7:0] imm_ext,
  output logic [7:0] operand,
  output logic [1:0] alu_op,
  output logic       acc_load,
  output logic [7:0] pc,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;

  logic       is_mem_op, is_ldi, is_jump, is_jz, is_hlt;
  logic [1:0] dec_alu_op;

  instr_decode u_decode (
    .ir        (ir_q),
    .is_mem_op (is_mem_op),
    .is_ldi    (is_ldi),
    .is_jump   (is_jump),
    .is_jz     (is_jz),
    .is_hlt    (is_hlt),
    .alu_op    (dec_alu_op)
  );

  assign imm_ext = zext5(ir_q[4:0]);
  assign operand = operand_q;
  assign pc      = pc_q;

  // Reset drops any in-flight handshake: no capture happens on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= 8'h00;
      ir_q      <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    mem_req   = 1'b0;
    mem_addr  = pc_q;
    mux_sel   = 1'b0;
    acc_load  = 1'b0;
    alu_op    = ALU_ADD;
    halted    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (is_hlt) begin
          state_d = ST_HALT;
        end else if (is_mem_op) begin
          state_d = ST_MEMRD;
        end else if (is_ldi) begin
          state_d = ST_EXEC;
        end else if (is_jump || (is_jz && zero_flag)) begin
          pc_d = imm_ext;
        end
      end
      ST_MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = imm_ext;
        alu_op   = dec_alu_op;
        if (mem_ready) begin
          operand_d = mem_rdata;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        acc_load = 1'b1;
        mux_sel  = is_ldi;
        alu_op   = dec_alu_op;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench with ISA-level reference interpreter for control_sequencer
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata;
  logic       zero_flag;
  logic       mux_sel;
  logic [7:0] imm_ext;
  logic [7:0] operand;
  logic [1:0] alu_op;
  logic       acc_load;
  logic [7:0] pc;
  logic       halted;

  logic [7:0] mem [256];
  logic [7:0] acc;
  logic       zf_ovr_en = 1'b0;
  logic       zf_ovr = 1'b0;
  logic       sb_en = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         kind;   // 0 bus read, 1 accumulator write, 2 halt
    logic [7:0] a;
    logic       m;
    logic [1:0] op;
    logic [7:0] v;
  } ev_t;

  ev_t q[$];

  control_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .zero_flag (zero_flag),
    .mux_sel   (mux_sel),
    .imm_ext   (imm_ext),
    .operand   (operand),
    .alu_op    (alu_op),
    .acc_load  (acc_load),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign zero_flag = zf_ovr_en ? zf_ovr : (acc == 8'h00);

  // Accumulator datapath downstream of the sequencer
  always @(posedge clk) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else if (acc_load) begin
      if (mux_sel) begin
        acc <= imm_ext;
      end else begin
        case (alu_op)
          2'b00:   acc <= acc + operand;
          2'b01:   acc <= acc - operand;
          2'b10:   acc <= acc & operand;
          default: acc <= operand;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input int kind, input logic [7:0] a, input logic m,
                               input logic [1:0] op, input logic [7:0] v);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.m    = m;
    e.op   = op;
    e.v    = v;
    q.push_back(e);
  endfunction

  task automatic observe(input int kind, input logic [7:0] a, input logic m,
                         input logic [1:0] op, input logic [7:0] v);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event kind %0d addr %0h, expected none", kind, a);
    end else begin
      e = q.pop_front();
      check("sb_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind == 0) begin
          check("sb_addr", a, e.a);
        end else if (kind == 1) begin
          check("sb_mux_sel", m, e.m);
          if (!e.m) check("sb_alu_op", op, e.op);
          check("sb_value", v, e.v);
        end
      end
    end
  endtask

  logic       prev_wait = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic       prev_halted = 1'b0;

  always @(negedge clk) begin
    if (prev_wait) begin
      check("req_hold", mem_req, 1);
      check("addr_hold", mem_addr, prev_addr);
    end
    if (sb_en) begin
      if (mem_req && mem_ready) observe(0, mem_addr, 1'b0, 2'b00, 8'h00);
      if (acc_load) observe(1, 8'h00, mux_sel, alu_op, mux_sel ? imm_ext : operand);
      if (halted && !prev_halted) observe(2, 8'h00, 1'b0, 2'b00, 8'h00);
      if (halted) check("halt_no_req", mem_req, 0);
    end
    prev_wait   <= rst_n && mem_req && !mem_ready;
    prev_addr   <= mem_addr;
    prev_halted <= halted;
  end

  // ISA-level interpreter: expected bus reads and accumulator writes per instruction
  task automatic gen_program(input int n, output int halts);
    logic [7:0] ipc, ir, im, d, acc_m;
    logic [2:0] op;
    logic [2:0] aop;
    ipc   = 8'h00;
    acc_m = 8'h00;
    halts = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < n; k++) begin
      push(0, ipc, 1'b0, 2'b00, 8'h00);
      ir  = mem[ipc];
      ipc = ipc + 8'd1;
      op  = ir[7:5];
      im  = {3'b000, ir[4:0]};
      case (op)
        3'd1: begin
          push(1, 8'h00, 1'b1, 2'b00, im);
          acc_m = im;
        end
        3'd2, 3'd3, 3'd4: begin
          d   = mem[im];
          aop = op - 3'd2;
          push(0, im, 1'b0, 2'b00, 8'h00);
          push(1, 8'h00, 1'b0, aop[1:0], d);
          if (op == 3'd2)      acc_m = acc_m + d;
          else if (op == 3'd3) acc_m = acc_m - d;
          else                 acc_m = acc_m & d;
        end
        3'd5: ipc = im;
        3'd6: if (acc_m == 8'h00) ipc = im;
        3'd7: begin
          push(2, 8'h00, 1'b0, 2'b00, 8'h00);
          halts = 1;
          break;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    int h;
    int budget;

    // Reset state and LDI 5 with zero-wait memory
    clear_mem();
    mem[0] = 8'h25;
    mem_ready = 1'b1;
    do_reset();
    check("rst_mem_req", mem_req, 1);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_pc", pc, 8'h00);
    check("rst_operand", operand, 8'h00);
    check("rst_imm_ext", imm_ext, 8'h00);
    check("rst_mux_sel", mux_sel, 0);
    check("rst_acc_load", acc_load, 0);
    check("rst_halted", halted, 0);
    check("rst_alu_op", alu_op, 0);
    tick();
    check("ldi_c2_acc_load", acc_load, 0);
    tick();
    check("ldi_c3_acc_load", acc_load, 1);
    check("ldi_c3_mux_sel", mux_sel, 1);
    check("ldi_c3_imm_ext", imm_ext, 8'h05);
    tick();
    check("ldi_c4_mem_req", mem_req, 1);
    check("ldi_c4_mem_addr", mem_addr, 8'h01);

    // ADD 0x43 with two wait cycles on each read
    clear_mem();
    mem[0] = 8'h43;
    mem[3] = 8'h10;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      mem_ready = (c == 3) || (c == 7) || (c == 9);
      if (c == 4) check("add_c4_decode_req", mem_req, 0);
      if (c == 5) begin
        check("add_memrd_req", mem_req, 1);
        check("add_memrd_addr", mem_addr, 8'h03);
        check("add_memrd_alu_op", alu_op, 2'b00);
      end
      if (c == 7) check("add_c7_acc_load", acc_load, 0);
      if (c == 8) begin
        check("add_exec_acc_load", acc_load, 1);
        check("add_exec_mux_sel", mux_sel, 0);
        check("add_exec_alu_op", alu_op, 2'b00);
        check("add_exec_operand", operand, 8'h10);
      end
      if (c == 9) begin
        check("add_c9_mem_req", mem_req, 1);
        check("add_c9_mem_addr", mem_addr, 8'h01);
        check("add_c9_acc_load", acc_load, 0);
      end
      if (c < 9) tick();
    end

    // JZ 0xC7 at pc 4, taken and not taken
    for (int zf = 1; zf >= 0; zf--) begin
      clear_mem();
      mem[4] = 8'hC7;
      mem_ready = 1'b1;
      zf_ovr_en = 1'b1;
      zf_ovr = (zf == 1);
      do_reset();
      for (int c = 1; c < 9; c++) tick();
      check("jz_fetch_addr", mem_addr, 8'h04);
      tick();
      tick();
      check("jz_next_req", mem_req, 1);
      check("jz_next_addr", mem_addr, (zf == 1) ? 8'h07 : 8'h05);
      zf_ovr_en = 1'b0;
    end

    // pc wrap through 0xFF with NOPs everywhere
    clear_mem();
    mem_ready = 1'b1;
    do_reset();
    for (int c = 1; c < 511; c++) tick();
    check("wrap_fetch_ff", mem_addr, 8'hFF);
    tick();
    check("wrap_pc_00", pc, 8'h00);
    tick();
    check("wrap_fetch_00", mem_addr, 8'h00);

    // HLT is absorbing until reset
    clear_mem();
    mem[0] = 8'hE0;
    do_reset();
    tick();
    tick();
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      check("hlt_halted", halted, 1);
      check("hlt_mem_req", mem_req, 0);
      tick();
    end
    mem_ready = 1'b1;
    do_reset();
    check("hlt_rst_halted", halted, 0);
    check("hlt_rst_mem_req", mem_req, 1);
    check("hlt_rst_mem_addr", mem_addr, 8'h00);

    // Reset during MEMRD with mem_ready high
    clear_mem();
    mem[0] = 8'h43;
    mem[3] = 8'h10;
    do_reset();
    tick();
    tick();
    check("mrst_in_memrd_addr", mem_addr, 8'h03);
    do_reset();
    check("mrst_operand", operand, 8'h00);
    check("mrst_acc_load", acc_load, 0);
    check("mrst_mem_req", mem_req, 1);
    check("mrst_mem_addr", mem_addr, 8'h00);
    check("mrst_pc", pc, 8'h00);
    tick();
    check("mrst_c2_acc_load", acc_load, 0);

    // Random programs against the ISA interpreter
    for (int p = 0; p < 12; p++) begin
      rst_n = 1'b0;
      tick();
      q.delete();
      gen_program(30, h);
      rst_n = 1'b1;
      sb_en = 1'b1;
      budget = 0;
      while (q.size() != 0 && budget < 3000) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        tick();
        budget++;
      end
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL rand_timeout: %0d events left, expected 0", q.size());
      end
      if (h != 0) begin
        for (int c = 0; c < 5; c++) begin
          mem_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      sb_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
